priority_arbiter: RTL

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

---
 rtl/priority_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - 4-way fixed-priority / round-robin arbiter with hold limit
module priority_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  gnt_id_q, gnt_id_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic        preempt_q, preempt_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  last_id_q, last_id_d;

  logic [1:0]  fixed_id, rr_id, win_id, rr_idx;

  always_comb begin
    fixed_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) fixed_id = 2'(i);
    end
    // Walk offsets from farthest to nearest so the nearest set bit after last_id wins.
    rr_id  = 2'd0;
    rr_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = last_id_q + 2'(k + 1);
      if (req[rr_idx]) rr_id = rr_idx;
    end
    win_id = mode ? rr_id : fixed_id;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    hold_d      = hold_q;
    last_id_d   = last_id_q;
    case (state_q)
      S_IDLE: begin
        if (req != 4'b0000) begin
          state_d     = S_GRANT;
          gnt_d       = 4'b0001 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_d      = 8'd0;
          last_id_d   = win_id;
        end
      end
      S_GRANT: begin
        // Voluntary release outranks the hold-limit preemption.
        if (!req[gnt_id_q] || hold_q == HOLD_LAST) begin
          state_d     = S_IDLE;
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
          hold_d      = 8'd0;
          preempt_d   = req[gnt_id_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_q      <= 8'd0;
      last_id_q   <= 2'd3;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      hold_q      <= hold_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule
